uart_rx_classifier: RTL and testbench

Upstream stage of the string-checking FSM. It receives bytes on a serial 8N1 line and registers each received byte. It classifies the byte into the character-class flags that the checker consumes and pulses valid once per good byte. A framing error produces an error_verify pulse, which forces the checker's ERROR state back to IDLE.

---
 rtl/uart_pkg.sv | 51 +++++
 rtl/uart_rx_classifier_char_class.sv | 47 ++++
 rtl/uart_rx_classifier.sv | 169 ++++++++++++++++
 tb/tb_uart_rx_classifier.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared definitions for the UART receive / character classification path.
package uart_pkg;

   // Receiver FSM states
   typedef enum logic [2:0] {
      IDLE  = 3'd0,
      START = 3'd1,
      DATA  = 3'd2,
      STOP  = 3'd3,
      BREAK = 3'd4
   } rx_state_e;

   // ASCII boundaries used by the classifier
   localparam logic [7:0] CH_NUL    = 8'h00;
   localparam logic [7:0] CH_TAB    = 8'h09;
   localparam logic [7:0] CH_LF     = 8'h0A;
   localparam logic [7:0] CH_CR     = 8'h0D;
   localparam logic [7:0] CH_SPACE  = 8'h20;
   localparam logic [7:0] CH_DIG_0  = 8'h30;
   localparam logic [7:0] CH_DIG_9  = 8'h39;
   localparam logic [7:0] CH_UP_A   = 8'h41;
   localparam logic [7:0] CH_UP_F   = 8'h46;
   localparam logic [7:0] CH_UP_Z   = 8'h5A;
   localparam logic [7:0] CH_LOW_A  = 8'h61;
   localparam logic [7:0] CH_LOW_F  = 8'h66;
   localparam logic [7:0] CH_LOW_Z  = 8'h7A;

   // Bit positions inside the class vector
   localparam int NUM_CLASSES    = 14;
   localparam int CL_START_STOP  = 0;
   localparam int CL_SMALL       = 1;
   localparam int CL_CAPITAL     = 2;
   localparam int CL_NUMBER      = 3;
   localparam int CL_HEX         = 4;
   localparam int CL_PUNCT_BASIC = 5;
   localparam int CL_PUNCT_FIN   = 6;
   localparam int CL_PAREN       = 7;
   localparam int CL_CURLY       = 8;
   localparam int CL_MATH        = 9;
   localparam int CL_WHITESPACE  = 10;
   localparam int CL_VOWEL       = 11;
   localparam int CL_CONSONANT   = 12;
   localparam int CL_OTHER       = 13;

   // Inclusive range test on a byte
   function automatic logic in_range(input logic [7:0] c, input logic [7:0] lo,
                                     input logic [7:0] hi);
      return (c >= lo) && (c <= hi);
   endfunction

endpackage

// File: rtl/uart_rx_classifier_char_class.sv
// Purely combinational byte classifier producing the multi-hot class vector.
module char_class
   import uart_pkg::*;
(
   input  logic [7:0]             ch,
   output logic [NUM_CLASSES-1:0] cls
);

   // Decode every class; 'other' is whatever no primary class claimed
   always_comb begin
      cls = '0;
      cls[CL_START_STOP] = (ch == CH_NUL);
      cls[CL_SMALL]      = in_range(ch, CH_LOW_A, CH_LOW_Z);
      cls[CL_CAPITAL]    = in_range(ch, CH_UP_A, CH_UP_Z);
      cls[CL_NUMBER]     = in_range(ch, CH_DIG_0, CH_DIG_9);
      cls[CL_HEX]        = in_range(ch, CH_DIG_0, CH_DIG_9) |
                           in_range(ch, CH_UP_A, CH_UP_F) |
                           in_range(ch, CH_LOW_A, CH_LOW_F);
      cls[CL_WHITESPACE] = (ch == CH_SPACE) | (ch == CH_TAB) |
                           (ch == CH_LF) | (ch == CH_CR);
      case (ch)
         8'h2E, 8'h2C, 8'h3A, 8'h3B, 8'h21, 8'h3F, 8'h27, 8'h22:
            cls[CL_PUNCT_BASIC] = 1'b1;                 // . , : ; ! ? ' "
         8'h23, 8'h24, 8'h25, 8'h26, 8'h40:
            cls[CL_PUNCT_FIN] = 1'b1;                   // # $ % & @
         8'h28, 8'h29, 8'h5B, 8'h5D:
            cls[CL_PAREN] = 1'b1;                       // ( ) [ ]
         8'h7B, 8'h7D:
            cls[CL_CURLY] = 1'b1;                       // { }
         8'h2B, 8'h2D, 8'h2A, 8'h2F, 8'h5C, 8'h3D, 8'h3C, 8'h3E:
            cls[CL_MATH] = 1'b1;                        // + - * / \ = < >
         default: ;
      endcase
      case (ch)
         8'h61, 8'h65, 8'h69, 8'h6F, 8'h75,
         8'h41, 8'h45, 8'h49, 8'h4F, 8'h55:
            cls[CL_VOWEL] = 1'b1;
         default: ;
      endcase
      cls[CL_CONSONANT] = (cls[CL_SMALL] | cls[CL_CAPITAL]) & ~cls[CL_VOWEL];
      cls[CL_OTHER] = ~(cls[CL_START_STOP] | cls[CL_SMALL] | cls[CL_CAPITAL] |
                        cls[CL_NUMBER] | cls[CL_PUNCT_BASIC] | cls[CL_PUNCT_FIN] |
                        cls[CL_PAREN] | cls[CL_CURLY] | cls[CL_MATH] |
                        cls[CL_WHITESPACE]);
   end

endmodule

// File: rtl/uart_rx_classifier.sv
// 8N1 serial receiver that registers each good byte with its class flags
// and reports framing errors as a single pulse.
module uart_rx_classifier
   import uart_pkg::*;
#(
   parameter int CLKS_PER_BIT = 16,
   parameter int SYNC_STAGES  = 2
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       rx,
   output logic       valid,
   output logic [7:0] data,
   output logic       error_verify,
   output logic       start_stop,
   output logic       small_letter,
   output logic       capital_letter,
   output logic       number,
   output logic       hex_digit,
   output logic       punctuation_basic,
   output logic       punctuation_finance,
   output logic       parentheses,
   output logic       curly_braces,
   output logic       math_symbol,
   output logic       whitespace,
   output logic       vowel,
   output logic       consonant,
   output logic       other
);

   localparam int CW = $clog2(CLKS_PER_BIT);
   localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);
   localparam logic [CW-1:0] CNT_MID  = CW'(CLKS_PER_BIT / 2 - 1);

   logic [SYNC_STAGES-1:0] sync_reg;
   logic                   rx_s;
   rx_state_e              state_reg, state_next;
   logic [CW-1:0]          cnt_reg, cnt_next;
   logic [2:0]             bi_reg, bi_next;
   logic [7:0]             shift_reg, shift_next;
   logic                   good_next, err_next;
   logic                   valid_reg, err_reg;
   logic [7:0]             data_reg;
   logic [NUM_CLASSES-1:0] flags_reg, cls_w;

   assign rx_s = sync_reg[SYNC_STAGES-1];

   // Metastability synchroniser; resets to the idle (high) line level
   always_ff @(posedge clk) begin
      if (rst) sync_reg <= '1;
      else     sync_reg <= {sync_reg[SYNC_STAGES-2:0], rx};
   end

   // Receiver state, baud counter, bit index and shift register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_reg <= IDLE;
         cnt_reg   <= '0;
         bi_reg    <= '0;
         shift_reg <= '0;
      end else begin
         state_reg <= state_next;
         cnt_reg   <= cnt_next;
         bi_reg    <= bi_next;
         shift_reg <= shift_next;
      end
   end

   // Next-state logic; samples land mid-bit because START only waits half a bit
   always_comb begin
      state_next = state_reg;
      cnt_next   = cnt_reg;
      bi_next    = bi_reg;
      shift_next = shift_reg;
      good_next  = 1'b0;
      err_next   = 1'b0;
      unique case (state_reg)
         IDLE: begin
            if (!rx_s) begin
               state_next = START;
               cnt_next   = '0;
            end
         end
         START: begin
            if (cnt_reg == CNT_MID) begin
               if (rx_s) begin
                  state_next = IDLE;
               end else begin
                  state_next = DATA;
                  cnt_next   = '0;
                  bi_next    = '0;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         DATA: begin
            if (cnt_reg == CNT_LAST) begin
               cnt_next           = '0;
               shift_next[bi_reg] = rx_s;
               if (bi_reg == 3'd7) state_next = STOP;
               else                bi_next    = bi_reg + 3'd1;
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         STOP: begin
            if (cnt_reg == CNT_LAST) begin
               cnt_next = '0;
               if (rx_s) begin
                  good_next  = 1'b1;
                  state_next = IDLE;
               end else begin
                  err_next   = 1'b1;
                  state_next = BREAK;
               end
            end else begin
               cnt_next = cnt_reg + 1'b1;
            end
         end
         BREAK: begin
            // Hold here until the line recovers so a stuck-low line pulses once
            if (rx_s) state_next = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   char_class u_char_class (
      .ch  (shift_reg),
      .cls (cls_w)
   );

   // Output registers: data/flags only move on a good byte
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_reg <= 1'b0;
         err_reg   <= 1'b0;
         data_reg  <= '0;
         flags_reg <= '0;
      end else begin
         valid_reg <= good_next;
         err_reg   <= err_next;
         if (good_next) begin
            data_reg  <= shift_reg;
            flags_reg <= cls_w;
         end
      end
   end

   assign valid               = valid_reg;
   assign error_verify        = err_reg;
   assign data                = data_reg;
   assign start_stop          = flags_reg[CL_START_STOP];
   assign small_letter        = flags_reg[CL_SMALL];
   assign capital_letter      = flags_reg[CL_CAPITAL];
   assign number              = flags_reg[CL_NUMBER];
   assign hex_digit           = flags_reg[CL_HEX];
   assign punctuation_basic   = flags_reg[CL_PUNCT_BASIC];
   assign punctuation_finance = flags_reg[CL_PUNCT_FIN];
   assign parentheses         = flags_reg[CL_PAREN];
   assign curly_braces        = flags_reg[CL_CURLY];
   assign math_symbol         = flags_reg[CL_MATH];
   assign whitespace          = flags_reg[CL_WHITESPACE];
   assign vowel               = flags_reg[CL_VOWEL];
   assign consonant           = flags_reg[CL_CONSONANT];
   assign other               = flags_reg[CL_OTHER];

endmodule

// File: tb/tb_uart_rx_classifier.sv
// Scoreboard bench: stimulus queues expected pulses, a negedge monitor checks them.
module tb_uart_rx_classifier;

   localparam int CPB = 4;

   // Observed flag vector, packed in bench order:
   // 0 start_stop 1 small 2 capital 3 number 4 hex 5 punct_basic 6 punct_fin
   // 7 paren 8 curly 9 math 10 whitespace 11 vowel 12 consonant 13 other
   localparam logic [13:0] F_NONE  = 14'h0000;
   localparam logic [13:0] F_LOW_A = 14'h0812;  // small, hex, vowel
   localparam logic [13:0] F_NUL   = 14'h0001;  // start_stop
   localparam logic [13:0] F_FIVE  = 14'h0018;  // number, hex
   localparam logic [13:0] F_TILDE = 14'h2000;  // other
   localparam logic [13:0] F_QUOTE = 14'h0020;  // punctuation_basic
   localparam logic [13:0] F_CURLY = 14'h0100;  // curly_braces
   localparam logic [13:0] F_SPACE = 14'h0400;  // whitespace
   localparam logic [13:0] F_UP_E  = 14'h0814;  // capital, hex, vowel
   localparam logic [13:0] F_HASH  = 14'h0040;  // punctuation_finance
   localparam logic [13:0] F_LOW_Z = 14'h1002;  // small, consonant

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       rx  = 1'b1;
   logic       valid, error_verify;
   logic [7:0] data;
   logic       start_stop, small_letter, capital_letter, number, hex_digit;
   logic       punctuation_basic, punctuation_finance, parentheses, curly_braces;
   logic       math_symbol, whitespace, vowel, consonant, other;
   logic [13:0] obs;

   typedef struct {
      bit          is_err;
      logic [7:0]  data;
      logic [13:0] flags;
   } exp_t;

   exp_t exp_q[$];
   int   n_vec = 0;
   int   n_miss = 0;
   int   cyc = 0;
   int   zero_req = 0;
   int   zero_done = 0;
   bit   done_req = 1'b0;

   always #5 clk = ~clk;

   assign obs = {other, consonant, vowel, whitespace, math_symbol, curly_braces,
                 parentheses, punctuation_finance, punctuation_basic, hex_digit,
                 number, capital_letter, small_letter, start_stop};

   uart_rx_classifier #(.CLKS_PER_BIT(CPB), .SYNC_STAGES(2)) dut (
      .clk                 (clk),
      .rst                 (rst),
      .rx                  (rx),
      .valid               (valid),
      .data                (data),
      .error_verify        (error_verify),
      .start_stop          (start_stop),
      .small_letter        (small_letter),
      .capital_letter      (capital_letter),
      .number              (number),
      .hex_digit           (hex_digit),
      .punctuation_basic   (punctuation_basic),
      .punctuation_finance (punctuation_finance),
      .parentheses         (parentheses),
      .curly_braces        (curly_braces),
      .math_symbol         (math_symbol),
      .whitespace          (whitespace),
      .vowel               (vowel),
      .consonant           (consonant),
      .other               (other)
   );

   // Serial frame driver; caller is positioned on a negedge
   task automatic send_frame(input logic [7:0] b, input bit stop_ok);
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 8; i++) begin
         rx = b[i];
         repeat (CPB) @(negedge clk);
      end
      if (stop_ok) begin
         rx = 1'b1;
         repeat (CPB) @(negedge clk);
      end else begin
         rx = 1'b0;
         repeat (4 * CPB) @(negedge clk);   // bad stop bit plus three bit-times low
         rx = 1'b1;
         repeat (CPB) @(negedge clk);
      end
   endtask

   task automatic expect_good(input logic [7:0] b, input logic [13:0] f);
      exp_t e;
      e.is_err = 1'b0;
      e.data   = b;
      e.flags  = f;
      exp_q.push_back(e);
   endtask

   task automatic expect_err(input logic [7:0] held_data, input logic [13:0] held_flags);
      exp_t e;
      e.is_err = 1'b1;
      e.data   = held_data;
      e.flags  = held_flags;
      exp_q.push_back(e);
   endtask

   task automatic finish_run();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
      $finish;
   endtask

   // Monitor: pops one expectation per output pulse, runs idle-zero checks on request
   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (!rst) begin
         if (valid && error_verify) begin
            n_vec++; n_miss++;
            $display("FAIL pulse_overlap: valid=%0b error_verify=%0b required not both 1",
                     valid, error_verify);
         end
         if (valid || error_verify) begin
            if (exp_q.size() == 0) begin
               n_vec++; n_miss++;
               $display("FAIL unexpected_pulse: valid=%0b error_verify=%0b data=%02h, required no pulse",
                        valid, error_verify, data);
            end else begin
               e = exp_q.pop_front();
               n_vec++;
               if (error_verify !== e.is_err) begin
                  n_miss++;
                  $display("FAIL pulse_kind: error_verify=%0b required %0b", error_verify, e.is_err);
               end
               n_vec++;
               if (data !== e.data) begin
                  n_miss++;
                  $display("FAIL data: got %02h required %02h", data, e.data);
               end
               n_vec++;
               if (obs !== e.flags) begin
                  n_miss++;
                  $display("FAIL flags: got %04h required %04h (data %02h)", obs, e.flags, e.data);
               end
               $display("pulse %s data=%02h flags=%04h", e.is_err ? "err  " : "valid", data, obs);
            end
         end
         if (zero_req != zero_done) begin
            zero_done = zero_req;
            n_vec++;
            if ({valid, error_verify, data, obs} !== {2'b00, 8'h00, F_NONE}) begin
               n_miss++;
               $display("FAIL reset_state: valid=%0b err=%0b data=%02h flags=%04h required all 0",
                        valid, error_verify, data, obs);
            end else begin
               $display("reset state check: outputs 0");
            end
         end
         if (done_req) begin
            n_vec++;
            if (exp_q.size() != 0) begin
               n_miss++;
               $display("FAIL missing_pulses: %0d outstanding required 0", exp_q.size());
            end
            finish_run();
         end
      end
      if (cyc > 20000) begin
         n_vec++; n_miss++;
         $display("FAIL timeout: cycle %0d reached with %0d pulses outstanding", cyc, exp_q.size());
         finish_run();
      end
   end

   // Stimulus
   initial begin
      rst = 1'b1;
      rx  = 1'b1;
      repeat (4) @(negedge clk);
      rst = 1'b0;
      zero_req++;
      repeat (3) @(negedge clk);

      // 'a'
      expect_good(8'h61, F_LOW_A);
      send_frame(8'h61, 1'b1);
      repeat (2) @(negedge clk);

      // NUL then '5', back-to-back
      expect_good(8'h00, F_NUL);
      expect_good(8'h35, F_FIVE);
      send_frame(8'h00, 1'b1);
      send_frame(8'h35, 1'b1);

      // '~' then '"'
      expect_good(8'h7E, F_TILDE);
      send_frame(8'h7E, 1'b1);
      expect_good(8'h22, F_QUOTE);
      send_frame(8'h22, 1'b1);
      repeat (2) @(negedge clk);

      // Framing error on 0x41: one pulse, data/flags still from '"'
      expect_err(8'h22, F_QUOTE);
      send_frame(8'h41, 1'b0);
      repeat (2 * CPB) @(negedge clk);
      expect_good(8'h7B, F_CURLY);
      send_frame(8'h7B, 1'b1);
      repeat (2) @(negedge clk);

      // One-clock start glitch, then a space
      rx = 1'b0;
      @(negedge clk);
      rx = 1'b1;
      repeat (3 * CPB) @(negedge clk);
      expect_good(8'h20, F_SPACE);
      send_frame(8'h20, 1'b1);
      repeat (2) @(negedge clk);

      // Reset in the middle of the data bits of 0x45
      rx = 1'b0;
      repeat (CPB) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         rx = 8'h45 >> i;
         repeat (CPB) @(negedge clk);
      end
      rst = 1'b1;
      rx  = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      zero_req++;
      repeat (3 * CPB) @(negedge clk);

      expect_good(8'h45, F_UP_E);
      send_frame(8'h45, 1'b1);
      expect_good(8'h23, F_HASH);
      send_frame(8'h23, 1'b1);
      expect_good(8'h7A, F_LOW_Z);
      send_frame(8'h7A, 1'b1);

      repeat (5 * CPB) @(negedge clk);
      done_req = 1'b1;
   end

endmodule
